tlp_receiver: RTL and testbench

Receive-side counterpart of the PCIe TLP symbol transmitter: consumes the framed 8-bit symbol stream (STP token, N payload symbols, optional EDB), reassembles the TLP into a 128-bit word and hands it to the transaction layer through a valid/ready output register. Nullified TLPs, terminated by EDB, are discarded. Stalled TLPs are dropped after a timeout. It sits between the symbol deframer and the TLP consumer.

---
 rtl/tlp_rx_pkg.sv | 19 +
 rtl/tlp_receiver_if.sv | 26 ++
 rtl/tlp_rx_out_buf.sv | 38 +++
 rtl/tlp_receiver.sv | 143 ++++++++++++++
 tb/tb_tlp_receiver.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/tlp_rx_pkg.sv
// tlp_receiver shared definitions: framing tokens, FSM states,
// and the length-field decoder.
package tlp_rx_pkg;

  localparam logic [7:0] TLP_STP = 8'hFA;
  localparam logic [7:0] TLP_EDB = 8'hFB;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EDB_CHECK
  } tlp_rx_state_e;

  // Length field 0 encodes the maximum of four DWs.
  function automatic logic [2:0] len_to_dw(input logic [1:0] enc);
    return (enc == 2'd0) ? 3'd4 : {1'b0, enc};
  endfunction

endpackage

// File: rtl/tlp_receiver_if.sv
// Symbol stream in, reassembled TLP out, plus the status pulses.
// master drives symbols and ready; slave is the receiver.
interface tlp_receiver_if;
  logic         rx_valid;
  logic [7:0]   rx_symbol;
  logic [1:0]   tlp_length;
  logic         tlp_out_ready;
  logic         tlp_out_valid;
  logic [127:0] tlp_out_data;
  logic [2:0]   tlp_out_dwords;
  logic         rx_nullified;
  logic         rx_error;
  logic         rx_overflow;

  modport master (
    output rx_valid, rx_symbol, tlp_length, tlp_out_ready,
    input  tlp_out_valid, tlp_out_data, tlp_out_dwords,
    input  rx_nullified, rx_error, rx_overflow
  );

  modport slave (
    input  rx_valid, rx_symbol, tlp_length, tlp_out_ready,
    output tlp_out_valid, tlp_out_data, tlp_out_dwords,
    output rx_nullified, rx_error, rx_overflow
  );
endinterface

// File: rtl/tlp_rx_out_buf.sv
// One-entry valid/ready holding register for committed TLPs.
// A commit that finds it full and unacknowledged is dropped.
module tlp_rx_out_buf (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         commit,
  input  logic [127:0] in_data,
  input  logic [2:0]   in_dwords,
  input  logic         ready,
  output logic         valid,
  output logic [127:0] data,
  output logic [2:0]   dwords,
  output logic         overflow
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      data     <= '0;
      dwords   <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (commit) begin
        if (!valid || ready) begin
          valid  <= 1'b1;
          data   <= in_data;
          dwords <= in_dwords;
        end else begin
          overflow <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tlp_receiver.sv
// TLP receiver: STP/payload/EDB deframing into a 128-bit word.
// TLP_RX_STATS_EN adds saturating good/nullified/error counters.
module tlp_receiver
  import tlp_rx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  tlp_receiver_if.slave rx
`ifdef TLP_RX_STATS_EN
  ,
  output logic [15:0] stat_good,
  output logic [15:0] stat_nullified,
  output logic [15:0] stat_error
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  tlp_rx_state_e state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [2:0]    len_q, len_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    sym_q [4];
  logic [7:0]    sym_d [4];
  logic          null_d, err_d, commit;
  logic [127:0]  pkt;

  logic is_stp, is_edb;
  assign is_stp = rx.rx_valid && (rx.rx_symbol == TLP_STP);
  assign is_edb = rx.rx_valid && (rx.rx_symbol == TLP_EDB);

  always_comb begin
    pkt = '0;
    for (int k = 0; k < 4; k++)
      pkt[127-32*k -: 8] = sym_q[k];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    tmo_d   = tmo_q;
    sym_d   = sym_q;
    null_d  = 1'b0;
    err_d   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (is_stp) begin
          state_d = COLLECT;
          len_d   = len_to_dw(rx.tlp_length);
          cnt_d   = '0;
          tmo_d   = '0;
          sym_d   = '{default: '0};
        end
      end
      COLLECT: begin
        if (rx.rx_valid) begin
          sym_d[cnt_q] = rx.rx_symbol;
          tmo_d = '0;
          cnt_d = cnt_q + 2'd1;
          if ({1'b0, cnt_q} == len_q - 3'd1)
            state_d = EDB_CHECK;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      EDB_CHECK: begin
        state_d = IDLE;
        if (is_edb) begin
          null_d = 1'b1;
        end else begin
          commit = 1'b1;
          // Back-to-back TLP: STP may land in the EDB window
          if (is_stp) begin
            state_d = COLLECT;
            len_d   = len_to_dw(rx.tlp_length);
            cnt_d   = '0;
            tmo_d   = '0;
            sym_d   = '{default: '0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      len_q           <= '0;
      tmo_q           <= '0;
      sym_q           <= '{default: '0};
      rx.rx_nullified <= 1'b0;
      rx.rx_error     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      len_q           <= len_d;
      tmo_q           <= tmo_d;
      sym_q           <= sym_d;
      rx.rx_nullified <= null_d;
      rx.rx_error     <= err_d;
    end
  end

  tlp_rx_out_buf u_out_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .commit    (commit),
    .in_data   (pkt),
    .in_dwords (len_q),
    .ready     (rx.tlp_out_ready),
    .valid     (rx.tlp_out_valid),
    .data      (rx.tlp_out_data),
    .dwords    (rx.tlp_out_dwords),
    .overflow  (rx.rx_overflow)
  );

`ifdef TLP_RX_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_good      <= '0;
      stat_nullified <= '0;
      stat_error     <= '0;
    end else begin
      if (commit && stat_good != 16'hFFFF)
        stat_good <= stat_good + 16'd1;
      if (null_d && stat_nullified != 16'hFFFF)
        stat_nullified <= stat_nullified + 16'd1;
      if (err_d && stat_error != 16'hFFFF)
        stat_error <= stat_error + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tlp_receiver.sv
// Randomized bench for tlp_receiver against a TLP-level model.
// Build with TLP_RX_STATS_EN to also check the counters.
module tb_tlp_receiver;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tlp_receiver_if bus ();

`ifdef TLP_RX_STATS_EN
  logic [15:0] stat_good, stat_nullified, stat_error;
`endif

  tlp_receiver #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (bus.slave)
`ifdef TLP_RX_STATS_EN
    ,
    .stat_good      (stat_good),
    .stat_nullified (stat_nullified),
    .stat_error     (stat_error)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: a TLP is a queue of payload bytes
  logic [7:0]   pl[$];
  bit           busy, window;
  int           need, idle_run;
  bit           m_valid, m_null, m_err, m_ovf;
  logic [127:0] m_data;
  logic [2:0]   m_dw;
  int           m_good, m_nulls, m_errs;

  function automatic logic [127:0] pack_tlp();
    logic [127:0] d = '0;
    foreach (pl[k]) d[127-32*k -: 8] = pl[k];
    return d;
  endfunction

  function automatic void m_start(input logic [1:0] l);
    busy = 1; idle_run = 0; pl.delete();
    need = (l == 0) ? 4 : int'(l);
  endfunction

  function automatic void m_reset();
    busy = 0; window = 0; pl.delete(); idle_run = 0;
    m_valid = 0; m_null = 0; m_err = 0; m_ovf = 0;
    m_data = '0; m_dw = '0;
    m_good = 0; m_nulls = 0; m_errs = 0;
  endfunction

  function automatic void m_step(input bit v, input logic [7:0] s,
                                 input logic [1:0] l, input bit r);
    bit commit = 0;
    logic [127:0] cd = '0;
    logic [2:0] cw = '0;
    m_null = 0; m_err = 0; m_ovf = 0;
    if (window) begin
      window = 0;
      if (v && s == 8'hFB) begin
        m_null = 1; m_nulls++;
      end else begin
        commit = 1; cd = pack_tlp(); cw = 3'(need);
        if (v && s == 8'hFA) m_start(l);
      end
    end else if (busy) begin
      if (v) begin
        pl.push_back(s); idle_run = 0;
        if (pl.size() == need) begin busy = 0; window = 1; end
      end else begin
        idle_run++;
        if (idle_run == TMO) begin busy = 0; m_err = 1; m_errs++; end
      end
    end else if (v && s == 8'hFA) begin
      m_start(l);
    end
    if (commit) begin
      m_good++;
      if (!m_valid || r) begin m_valid = 1; m_data = cd; m_dw = cw; end
      else m_ovf = 1;
    end else if (m_valid && r) begin
      m_valid = 0;
    end
  endfunction

  task automatic compare_all();
    check("valid", 128'(bus.tlp_out_valid), 128'(m_valid));
    check("data", bus.tlp_out_data, m_data);
    check("dwords", 128'(bus.tlp_out_dwords), 128'(m_dw));
    check("nullified", 128'(bus.rx_nullified), 128'(m_null));
    check("error", 128'(bus.rx_error), 128'(m_err));
    check("overflow", 128'(bus.rx_overflow), 128'(m_ovf));
`ifdef TLP_RX_STATS_EN
    check("stat_good", 128'(stat_good), 128'(m_good));
    check("stat_null", 128'(stat_nullified), 128'(m_nulls));
    check("stat_err", 128'(stat_error), 128'(m_errs));
`endif
  endtask

  task automatic cyc(input bit v, input logic [7:0] s,
                     input logic [1:0] l, input bit r);
    bus.rx_valid = v; bus.rx_symbol = s;
    bus.tlp_length = l; bus.tlp_out_ready = r;
    @(posedge clk);
    if (!rst_n) m_reset();
    else m_step(v, s, l, r);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(0, 8'h00, 2'd0, 0);
    cyc(0, 8'h00, 2'd0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.rx_valid = 0; bus.rx_symbol = 0;
    bus.tlp_length = 0; bus.tlp_out_ready = 0;
    m_reset();
    do_reset();

    // len 2 with a gap; held until ready
    cyc(1, 8'hFA, 2'd2, 0);
    cyc(0, 8'h00, 2'd2, 0);
    cyc(1, 8'h11, 2'd2, 0);
    cyc(1, 8'h22, 2'd2, 0);
    cyc(0, 8'h00, 2'd2, 0);
    cyc(0, 8'h00, 2'd2, 0);
    check("tp1_data", bus.tlp_out_data,
          128'h11000000_22000000_00000000_00000000);
    check("tp1_dw", 128'(bus.tlp_out_dwords), 128'd2);
    cyc(0, 8'h00, 2'd2, 0);
    cyc(0, 8'h00, 2'd2, 1);
    cyc(0, 8'h00, 2'd2, 0);

    // nullified len 3
    cyc(1, 8'hFA, 2'd3, 1);
    cyc(1, 8'hAA, 2'd3, 1);
    cyc(1, 8'hBB, 2'd3, 1);
    cyc(1, 8'hCC, 2'd3, 1);
    cyc(1, 8'hFB, 2'd3, 1);
    cyc(0, 8'h00, 2'd3, 1);

    // len 4, STP in EDB window starts the next (len 1)
    cyc(1, 8'hFA, 2'd0, 1);
    for (int i = 1; i <= 4; i++) cyc(1, 8'(i), 2'd0, 1);
    cyc(1, 8'hFA, 2'd1, 0);
    check("tp3_data", bus.tlp_out_data,
          128'h01000000_02000000_03000000_04000000);
    check("tp3_dw", 128'(bus.tlp_out_dwords), 128'd4);
    cyc(1, 8'h77, 2'd1, 1);
    cyc(0, 8'h00, 2'd1, 1);
    cyc(0, 8'h00, 2'd1, 1);

    // timeout, then a normal len-1 TLP
    cyc(1, 8'hFA, 2'd2, 1);
    cyc(1, 8'h11, 2'd2, 1);
    for (int i = 0; i < TMO + 1; i++) cyc(0, 8'h00, 2'd2, 1);
    cyc(1, 8'hFA, 2'd1, 1);
    cyc(1, 8'h55, 2'd1, 1);
    cyc(0, 8'h00, 2'd1, 0);
    cyc(0, 8'h00, 2'd1, 0);
    check("tp4_data", bus.tlp_out_data, {8'h55, 120'h0});
    cyc(0, 8'h00, 2'd1, 1);

    // two good TLPs with ready low: overflow
    for (int t = 0; t < 2; t++) begin
      cyc(1, 8'hFA, 2'd1, 0);
      cyc(1, 8'(8'hA0 + t), 2'd1, 0);
      cyc(0, 8'h00, 2'd1, 0);
      cyc(0, 8'h00, 2'd1, 0);
    end
    check("tp5_held", bus.tlp_out_data, {8'hA0, 120'h0});
    cyc(0, 8'h00, 2'd1, 1);

    // reset in the middle of a TLP
    cyc(1, 8'hFA, 2'd2, 1);
    cyc(1, 8'h11, 2'd2, 1);
    do_reset();
    check("rst_valid", 128'(bus.tlp_out_valid), 128'd0);
    cyc(1, 8'hFA, 2'd2, 0);
    cyc(1, 8'h33, 2'd2, 0);
    cyc(1, 8'h44, 2'd2, 0);
    cyc(0, 8'h00, 2'd2, 0);
    cyc(0, 8'h00, 2'd2, 1);

    // random symbol soup with occasional long gaps
    for (int i = 0; i < 4000; i++) begin
      int p = $urandom_range(99);
      bit v = ($urandom_range(99) < 70);
      logic [7:0] s = 8'($urandom);
      if (p < 25) s = 8'hFA;
      else if (p < 35) s = 8'hFB;
      if ($urandom_range(199) == 0)
        for (int g = 0; g < TMO + 2; g++)
          cyc(0, 8'h00, 2'($urandom), 1'($urandom));
      cyc(v, s, 2'($urandom), ($urandom_range(99) < 60));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
